// File: rtl/melody_sequencer.sv
// Melody player: walks a {rest, note, beats} song table, looks up each note's
// period and drives a square-wave buzzer for beats*BEAT_CYCLES clocks.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | sample the song word at song_addr
// LOAD   | latch the half-period of the addressed note
// TONE   | play (or rest) for the note's beats
// GAP    | silent articulation gap after a note
// FINISH | one-cycle done pulse, then back to IDLE
module melody_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int SONG_AW     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic [SONG_AW-1:0] song_addr,
    input  logic [8:0]         song_data,
    output logic [4:0]         note_addr,
    input  logic [31:0]        note_period,
    output logic               beep,
    output logic               busy,
    output logic               done
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0]      BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0]      GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [SONG_AW-1:0] SONG_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_TONE, S_GAP, S_FINISH
    } state_t;

    state_t      state;
    logic        rest_r;
    logic        silent_r;
    logic [2:0]  beats_left;
    logic [30:0] half_r;
    logic [30:0] tone_cnt;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] gap_cnt;

    logic last_entry;
    assign last_entry = (song_addr == SONG_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            song_addr  <= '0;
            note_addr  <= '0;
            beep       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rest_r     <= 1'b0;
            silent_r   <= 1'b0;
            beats_left <= '0;
            half_r     <= '0;
            tone_cnt   <= '0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
        end else if (stop && state != S_IDLE) begin
            state <= S_IDLE;
            beep  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        song_addr <= '0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (song_data[2:0] == 3'd0) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        note_addr  <= song_data[7:3];
                        rest_r     <= song_data[8];
                        beats_left <= song_data[2:0];
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Periods below 2 have no usable half-period; treat as silence.
                    half_r   <= note_period[31:1];
                    silent_r <= rest_r || (note_period < 32'd2);
                    tone_cnt <= '0;
                    beat_cnt <= '0;
                    beep     <= 1'b0;
                    state    <= S_TONE;
                end
                S_TONE: begin
                    if (!silent_r) begin
                        if (tone_cnt == half_r - 31'd1) begin
                            tone_cnt <= '0;
                            beep     <= ~beep;
                        end else begin
                            tone_cnt <= tone_cnt + 31'd1;
                        end
                    end
                    if (beat_cnt == BEAT_LAST) begin
                        beat_cnt <= '0;
                        if (beats_left == 3'd1) begin
                            beep <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                gap_cnt <= GAP_LAST;
                                state   <= S_GAP;
                            end else if (last_entry) begin
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end else begin
                                song_addr <= song_addr + 1'b1;
                                state     <= S_FETCH;
                            end
                        end else begin
                            beats_left <= beats_left - 3'd1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    beep <= 1'b0;
                    if (gap_cnt == '0) begin
                        // The last table entry ends the song; no wrap back to 0.
                        if (last_entry) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            song_addr <= song_addr + 1'b1;
                            state     <= S_FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_FINISH: begin
                    beep  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    beep  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: per-edge traces of the outputs are
// compared against hand-derived bit patterns (edge 0 = the edge that sees start).
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  song_addr;
    logic [8:0]  song_data;
    logic [4:0]  note_addr;
    logic [31:0] note_period;
    logic        beep;
    logic        busy;
    logic        done;

    logic [8:0]  song_mem [4];

    logic [63:0] beep_t, done_t, busy_t;
    logic [1:0]  song_log [64];
    logic [4:0]  note_log [64];

    int n_checks = 0;
    int n_fail   = 0;

    melody_sequencer #(
        .BEAT_CYCLES(8),
        .GAP_CYCLES (2),
        .SONG_AW    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .song_addr  (song_addr),
        .song_data  (song_data),
        .note_addr  (note_addr),
        .note_period(note_period),
        .beep       (beep),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign song_data   = song_mem[song_addr];
    assign note_period = {26'd0, note_addr, 1'b0} + 32'd4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start is driven for edge 0 and optionally again at pulse_at; stop and
    // reset are each applied for the single edge given (-1 = never).
    task automatic run(input int ncyc, input int stop_at, input int pulse_at, input int rst_at);
        beep_t = '0;
        done_t = '0;
        busy_t = '0;
        for (int i = 0; i < 64; i++) begin
            song_log[i] = '0;
            note_log[i] = '0;
        end
        for (int i = 0; i < ncyc; i++) begin
            start = (i == 0) || (i == pulse_at);
            stop  = (i == stop_at);
            rst   = !(i == rst_at);
            @(posedge clk);
            #1;
            beep_t[i]   = beep;
            done_t[i]   = done;
            busy_t[i]   = busy;
            song_log[i] = song_addr;
            note_log[i] = note_addr;
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b1;
    endtask

    task automatic load_song(input logic [8:0] a, input logic [8:0] b,
                             input logic [8:0] c, input logic [8:0] d);
        song_mem[0] = a;
        song_mem[1] = b;
        song_mem[2] = c;
        song_mem[3] = d;
    endtask

    localparam logic [8:0] NOTE0_B1 = {1'b0, 5'd0, 3'd1};
    localparam logic [8:0] NOTE1_B1 = {1'b0, 5'd1, 3'd1};
    localparam logic [8:0] NOTE2_B1 = {1'b0, 5'd2, 3'd1};
    localparam logic [8:0] REST_B2  = {1'b1, 5'd0, 3'd2};
    localparam logic [8:0] END_MARK = 9'd0;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        load_song(NOTE0_B1, END_MARK, END_MARK, END_MARK);
        repeat (3) @(posedge clk);
        #1;
        check("reset beep", {63'd0, beep}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset song_addr", {62'd0, song_addr}, 64'd0);
        check("reset note_addr", {59'd0, note_addr}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single note: half period 2, 8 TONE clocks on edges 3..10, GAP 11..12
        run(20, -1, -1, -1);
        check("single beep", beep_t, 64'h330);
        check("single done", done_t, 64'h2000);
        check("single busy", busy_t, 64'h3FFF);

        // rest for 2 beats then note 2 (half period 4)
        load_song(REST_B2, NOTE2_B1, END_MARK, END_MARK);
        run(40, -1, -1, -1);
        check("rest beep", beep_t, 64'h3C00_0000);
        check("rest done", done_t, 64'h2_0000_0000);
        check("rest busy", busy_t, 64'h3_FFFF_FFFF);
        check("rest note_addr", {59'd0, note_log[25]}, 64'd2);
        check("rest song_addr", {62'd0, song_log[25]}, 64'd1);

        // full table, no end marker: four notes then done, no wrap
        load_song(NOTE1_B1, NOTE1_B1, NOTE1_B1, NOTE1_B1);
        run(54, -1, -1, -1);
        check("full beep", beep_t, 64'h0000_0E00_E00E_00E0);
        check("full done", done_t, 64'h1_0000_0000_0000);
        check("full busy", busy_t, 64'h1_FFFF_FFFF_FFFF);
        check("full addr at done", {62'd0, song_log[48]}, 64'd3);
        check("full addr after", {62'd0, song_log[53]}, 64'd3);

        // stop in the 5th TONE clock of a single note
        load_song(NOTE0_B1, END_MARK, END_MARK, END_MARK);
        run(20, 7, -1, -1);
        check("stop beep", beep_t, 64'h30);
        check("stop busy", busy_t, 64'h7F);
        check("stop done", done_t, 64'd0);

        // stop while the second note is sounding; addresses hold
        load_song(REST_B2, NOTE2_B1, END_MARK, END_MARK);
        run(40, 27, -1, -1);
        check("stop2 beep", beep_t, 64'h400_0000);
        check("stop2 busy", busy_t, 64'h7FF_FFFF);
        check("stop2 done", done_t, 64'd0);
        check("stop2 song_addr", {62'd0, song_log[35]}, 64'd1);
        check("stop2 note_addr", {59'd0, note_log[35]}, 64'd2);

        // replay after stop starts again from entry 0
        run(40, -1, -1, -1);
        check("replay addr0", {62'd0, song_log[0]}, 64'd0);
        check("replay beep", beep_t, 64'h3C00_0000);
        check("replay done", done_t, 64'h2_0000_0000);

        // start and stop together in IDLE
        run(6, 0, -1, -1);
        check("start+stop busy", busy_t, 64'd0);

        // start pulsed during TONE is ignored
        load_song(NOTE0_B1, END_MARK, END_MARK, END_MARK);
        run(20, -1, 6, -1);
        check("ignore beep", beep_t, 64'h330);
        check("ignore done", done_t, 64'h2000);
        check("ignore busy", busy_t, 64'h3FFF);

        // reset during the GAP of note 2
        load_song(NOTE2_B1, END_MARK, END_MARK, END_MARK);
        run(20, -1, -1, 11);
        check("rstgap note before", {59'd0, note_log[10]}, 64'd2);
        check("rstgap beep", beep_t, 64'h3C0);
        check("rstgap busy", busy_t, 64'h7FF);
        check("rstgap done", done_t, 64'd0);
        check("rstgap note_addr", {59'd0, note_log[11]}, 64'd0);

        load_song(NOTE0_B1, END_MARK, END_MARK, END_MARK);
        run(20, -1, -1, -1);
        check("post-reset beep", beep_t, 64'h330);
        check("post-reset done", done_t, 64'h2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a stored melody on the board buzzer. Steps through a song table of {rest, note index, beats} words.
- Drives the note-index address of the note-period lookup table. Latches the returned period (clock cycles per tone period) and generates a square-wave beep from it.
- Times each note in beats, with a silent articulation gap between notes.
- Sits between the key/control logic (start/stop) and the period table plus buzzer pin.

Parameters:
- BEAT_CYCLES, 12500000, clocks per beat (0.25 s at 50 MHz); must be >= 1
- GAP_CYCLES, 1250000, silent clocks after every note; 0 = no gap
- SONG_AW, 4, song table address width; table depth 2**SONG_AW

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- start  in  1  begin playback from entry 0; ignored while busy
- stop  in  1  abort playback; priority over start
- song_addr  out  SONG_AW  song table read address
- song_data  in  9  combinational song word for song_addr: [8] rest, [7:3] note index 0..20, [2:0] beats (0 = end marker)
- note_addr  out  5  note index to the period table
- note_period  in  32  combinational period for note_addr, in clocks
- beep  out  1  buzzer square wave
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst low at a clk edge): state IDLE. song_addr=0, note_addr=0, beep=0, busy=0, done=0. All counters are cleared. Reset applies in any state, including mid-note. All outputs are registered.
- States: IDLE, FETCH, LOAD, TONE, GAP, FINISH.
- IDLE: start=1 and stop=0 -> song_addr<=0, go to FETCH.
- FETCH, 1 cycle: sample song_data.
  - beats==0 -> FINISH.
  - Otherwise note_addr<=[7:3], latch rest flag and beats, go to LOAD.
- LOAD, 1 cycle: period_r<=note_period, half_r<=note_period>>1. Clear the tone counter, beat counter and beep. Go to TONE.
- TONE lasts exactly beats*BEAT_CYCLES clocks:
  - The beat counter counts 0..BEAT_CYCLES-1. A beats-remaining counter decrements on each wrap. The last wrap goes to GAP.
  - Tone: the counter counts 0..half_r-1, and beep toggles when it reaches half_r-1, then it wraps to 0. First toggle occurs half_r clocks after TONE entry.
  - Silence: rest=1, or period_r<2 (half_r==0), holds beep=0 for the full duration.
- GAP: beep=0 for GAP_CYCLES clocks; GAP_CYCLES=0 makes GAP last 0 cycles, i.e. TONE exits directly to the advance step. Then advance:
  - song_addr==2**SONG_AW-1 -> FINISH, with no wrap fetch.
  - Otherwise song_addr+1 -> FETCH.
- FINISH: done=1 for one cycle, beep=0, go to IDLE. busy is low from the following cycle.
- stop=1 in any non-IDLE state: next state IDLE, beep=0, busy=0, done stays 0. song_addr and note_addr keep their values.
- start while busy is ignored. start and stop together in IDLE: remain IDLE.
- Counter widths: ceil(log2) of their maximum. Beat products are never formed as a 7*BEAT_CYCLES multiply; beats are counted instead.
- The 32-bit note_period is used unsigned. An odd period yields a half-period of floor(period/2), no error.

Test Plan:
- Bench setup: BEAT_CYCLES=8, GAP_CYCLES=2, SONG_AW=2. Bench period model is note_period = 2*note_addr+4.
- Single note: song = {note0, beats1}, {end}; start at edge 0.
  - beep toggles at edges 4, 6, 8, 10 (0->1->0->1->0).
  - beep is 0 during GAP.
  - done is high for one cycle after edge 13; busy is low after edge 14.
- Rest and multi-beat: song = {rest, beats2}, {note2, beats1}, {end}.
  - beep stays 0 for the first 16 TONE clocks.
  - The second note has half period 4: toggles every 4 clocks.
  - note_addr=2 during note 2.
- Table full, no end marker: 4 entries of {note1, beats1}.
  - Exactly 4 notes play, then done fires.
  - song_addr stays 3; no 5th FETCH of address 0.
- Stop mid-tone: assert stop in the 5th TONE clock of note 0.
  - Next cycle beep=0, busy=0.
  - done never asserts.
  - A later start replays from song_addr 0.
- Priority/ignore cases:
  - start+stop together in IDLE -> busy stays 0.
  - start pulsed during TONE -> timing identical to the single-note case.
- Reset mid-GAP: rst low for one edge -> all outputs 0 and state IDLE. A subsequent start plays normally from entry 0.
